// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, WIDTH+1 cycles per add.
// start/busy/done handshake; sum/cout/ovf are registered and update only when an add completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, acc_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, cout_q, ovf_q;
    logic [WIDTH-1:0] sum_q;

    logic             s_d, co_d, last_d;
    logic [WIDTH-1:0] acc_d;

    // Single full-adder slice fed from the operand shift registers.
    always_comb begin
        s_d    = sa_q[0] ^ sb_q[0] ^ c_q;
        co_d   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
        acc_d  = {s_d, acc_q[WIDTH-1:1]};
        last_d = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    acc_q <= acc_d;
                    c_q   <= co_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_d) begin
                        // c_q here is the carry into the MSB; co_d is the carry out of it.
                        sum_q   <= acc_d;
                        cout_q  <= co_d;
                        ovf_q   <= co_d ^ c_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, randomized adds at WIDTH=8,
// and an exhaustive sweep at WIDTH=2, all against an arithmetic reference model.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;
    int         errs   = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum[7:0]} for a w-bit add, from plain integer arithmetic.
    function automatic logic [9:0] ref_add(input int w, input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
        int unsigned mask, t, s, sx, sy, ss;
        logic [9:0]  r;
        mask = (32'd1 << w) - 1;
        t    = (x & mask) + (y & mask) + ci;
        s    = t & mask;
        sx   = (x >> (w - 1)) & 1;
        sy   = (y >> (w - 1)) & 1;
        ss   = (s >> (w - 1)) & 1;
        r[7:0] = s[7:0];
        r[8]   = ((t >> w) & 1) != 0;
        r[9]   = (sx == sy) && (ss != sx);
        return r;
    endfunction

    // One full add on the selected instance, checking every cycle from accept to the idle cycle after done.
    task automatic run_add(input int w, input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [9:0] r;
        logic       bz, dn, co, ov;
        logic [7:0] sm;
        r = ref_add(w, x, y, ci);
        @(negedge clk);
        if (w == 2) begin start2 = 1'b1; a2 = x[1:0]; b2 = y[1:0]; cin2 = ci; end
        else        begin start8 = 1'b1; a8 = x;      b8 = y;      cin8 = ci; end
        @(negedge clk);
        start2 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        for (int i = 1; i <= w; i++) begin
            bz = (w == 2) ? busy2 : busy8;
            dn = (w == 2) ? done2 : done8;
            chk("busy_shift", bz, 1'b1);
            chk("done_early", dn, 1'b0);
            @(negedge clk);
        end
        bz = (w == 2) ? busy2 : busy8;
        dn = (w == 2) ? done2 : done8;
        sm = (w == 2) ? {6'd0, sum2} : sum8;
        co = (w == 2) ? cout2 : cout8;
        ov = (w == 2) ? ovf2 : ovf8;
        chk("done_pulse", dn, 1'b1);
        chk("busy_done", bz, 1'b0);
        chk("sum", sm, r[7:0]);
        chk("cout", co, r[8]);
        chk("ovf", ov, r[9]);
        @(negedge clk);
        dn = (w == 2) ? done2 : done8;
        sm = (w == 2) ? {6'd0, sum2} : sum8;
        chk("done_clear", dn, 1'b0);
        chk("sum_hold", sm, r[7:0]);
    endtask

    initial begin
        logic [9:0] r2;
        logic [7:0] na, nb;
        logic       nc;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_sum", sum8, 8'h00);
        chk("rst_cout", cout8, 1'b0);
        chk("rst_ovf", ovf8, 1'b0);
        chk("rst_busy2", busy2, 1'b0);
        rst = 1'b0;

        run_add(8, 8'h03, 8'h05, 1'b0);
        run_add(8, 8'hFF, 8'h01, 1'b0);
        run_add(8, 8'hFF, 8'hFF, 1'b1);
        run_add(8, 8'h7F, 8'h01, 1'b0);
        run_add(8, 8'h80, 8'h80, 1'b0);

        // start pulses in SHIFT (cycle 3) and DONE (cycle 9) are ignored; held start from cycle 10 is accepted.
        na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom);
        r2 = ref_add(8, na, nb, nc);
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("ign_busy", busy8, ((cyc >= 1 && cyc <= 8) || (cyc >= 11 && cyc <= 18)));
                chk("ign_done", done8, (cyc == 9 || cyc == 19));
            end
            if (cyc == 9) begin
                chk("ign_sum", sum8, 8'h30);
                chk("ign_cout", cout8, 1'b0);
            end
            if (cyc == 19) begin
                chk("held_sum", sum8, r2[7:0]);
                chk("held_cout", cout8, r2[8]);
                chk("held_ovf", ovf8, r2[9]);
            end
            start8 = (cyc == 0 || cyc == 3 || (cyc >= 9 && cyc <= 19));
            if (cyc == 0)       begin a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; end
            else if (cyc >= 10) begin a8 = na;    b8 = nb;    cin8 = nc;   end
            else                begin a8 = 8'($urandom); b8 = 8'($urandom); end
        end
        @(negedge clk);

        // Reset in cycle 4 of an add aborts it with no done pulse.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", busy8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_busy", busy8, 1'b0);
            chk("abort_done", done8, 1'b0);
            chk("abort_res", {sum8, cout8, ovf8}, 10'd0);
            @(negedge clk);
        end

        // rst and start together in IDLE: nothing captured.
        rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        chk("rst_start_busy", busy8, 1'b0);
        @(negedge clk);
        chk("rst_start_busy2", busy8, 1'b0);
        run_add(8, 8'h01, 8'h01, 1'b0);

        for (int i = 0; i < 30; i++)
            run_add(8, 8'($urandom), 8'($urandom), 1'($urandom));

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    run_add(2, 8'(x), 8'(y), 1'(c));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
